rnn_input_feeder: RTL

- Upstream stage of the RNN core; buffers 32-bit input vectors x[t] pushed by the host/testbench.
- Presents the current word on idata and advances on each i_en request.
- Issues the one-shot ready start request to the core and tracks its busy window.
- Reports buffer level, underrun and completion.

---
 rtl/rnn_input_feeder_if.sv | 32 +++
 rtl/rnn_input_feeder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rnn_input_feeder_if.sv
// rnn_input_feeder_if -- bundle of the host push channel and the core-side
// signals of the RNN input feeder.
//   Host side : s_valid, s_data (in to feeder), s_ready (out of feeder)
//   Core side : busy, i_en (in to feeder), ready, idata (out of feeder)
//   Status    : level, underrun, done, word_cnt (out of feeder)
// modport slave  : the feeder itself
// modport master : whoever drives the host and core sides
interface rnn_input_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_ready;
  logic              busy;
  logic              i_en;
  logic              ready;
  logic [31:0]       idata;
  logic [ADDR_W:0]   level;
  logic              underrun;
  logic              done;
  logic [15:0]       word_cnt;

  modport slave (
    input  s_valid, s_data, busy, i_en,
    output s_ready, ready, idata, level, underrun, done, word_cnt
  );

  modport master (
    output s_valid, s_data, busy, i_en,
    input  s_ready, ready, idata, level, underrun, done, word_cnt
  );
endinterface

// File: rtl/rnn_input_feeder.sv
// rnn_input_feeder -- upstream stage of the RNN core.
// Buffers 32-bit input vectors pushed by the host in a circular FIFO and
// presents the oldest one in a show-ahead head register (idata). The core
// consumes the head with i_en. A small FSM issues a one-shot ready start
// request to the core, tracks its busy window and pulses done when it ends.
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high, clears all state
//   feed   : rnn_input_feeder_if.slave (push channel, core handshake, status)
// Optional build macro RNN_FEED_CNT_EN: when defined, word_cnt counts
// consumed words (wrapping, cleared on reset and on each new start);
// otherwise word_cnt is tied to zero.
module rnn_input_feeder #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int START_THRESH = 1
) (
  input  logic                clk,
  input  logic                reset,
  rnn_input_feeder_if.slave   feed
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_e;

  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] THRESH_L = (ADDR_W+1)'(START_THRESH);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       head_q;
  logic              head_valid_q;
  logic              underrun_q;
  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              s_ready_w;
  logic              push, pop, consume;
  logic [ADDR_W:0]   level_w;

  // A full FIFO refuses pushes even if a pop happens on the same edge.
  assign s_ready_w = (count_q < DEPTH_L);
  assign push      = feed.s_valid & s_ready_w;
  assign consume   = feed.i_en & head_valid_q;
  // The head is (re)loaded whenever it is empty or being consumed.
  assign pop       = (count_q != '0) & (~head_valid_q | feed.i_en);
  assign level_w   = count_q + {{ADDR_W{1'b0}}, head_valid_q};

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array carries no reset; only pointers and count define
  // which entries are meaningful, so clearing the data would be wasted logic.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= feed.s_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + 1'b1;
        head_q       <= mem_q[rd_ptr_q];
        head_valid_q <= 1'b1;
      end else if (consume) begin
        // idata keeps its last value once the buffer runs dry.
        head_valid_q <= 1'b0;
      end
      if (feed.i_en && !head_valid_q) underrun_q <= 1'b1;
    end
  end

  // Start/busy tracking FSM, outputs registered.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A core that is already busy is tracked without a start request.
        if (feed.busy) begin
          state_d = S_RUN;
        end else if (head_valid_q && (level_w >= THRESH_L)) begin
          state_d = S_START;
          ready_d = 1'b1;
        end
      end
      S_START: begin
        if (feed.busy) state_d = S_RUN;
        else           ready_d = 1'b1;
      end
      S_RUN: begin
        if (!feed.busy) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

`ifdef RNN_FEED_CNT_EN
  logic [15:0] word_cnt_q;
  logic        start_evt;

  assign start_evt = (state_q == S_IDLE) && (state_d == S_START);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          word_cnt_q <= '0;
    else if (start_evt) word_cnt_q <= '0;
    else if (consume)   word_cnt_q <= word_cnt_q + 1'b1;
  end

  assign feed.word_cnt = word_cnt_q;
`else
  assign feed.word_cnt = 16'h0000;
`endif

  assign feed.s_ready  = s_ready_w;
  assign feed.ready    = ready_q;
  assign feed.idata    = head_q;
  assign feed.level    = level_w;
  assign feed.underrun = underrun_q;
  assign feed.done     = done_q;

endmodule
